// File: rtl/jtkcpu_busresp.sv
// Target-side responder for the jtkcpu memory bus: one backend access per
// address strobe, with a minimum wait-state count and a timeout bus error.
module jtkcpu_busresp #(
    parameter int unsigned WAIT = 2,
    parameter int unsigned TOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic        cpu_as,
    input  logic        cpu_we,
    input  logic [23:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,
    output logic        dtack,
    output logic        bus_err,
    output logic        mem_cs,
    output logic        mem_we,
    output logic [23:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ok
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] WAIT_C = WAIT[3:0];
    localparam logic [7:0] TOUT_C = TOUT[7:0];

    logic [1:0]  state_q,     state_d;
    logic [3:0]  wcnt_q,      wcnt_d;
    logic [7:0]  tcnt_q,      tcnt_d;
    logic        ok_seen_q,   ok_seen_d;
    logic [7:0]  hold_q,      hold_d;
    logic [7:0]  cpu_din_q,   cpu_din_d;
    logic        dtack_q,     dtack_d;
    logic        bus_err_q,   bus_err_d;
    logic        mem_cs_q,    mem_cs_d;
    logic        mem_we_q,    mem_we_d;
    logic [23:0] mem_addr_q,  mem_addr_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;

    // Backend answer on this very clk; only meaningful while the request is live.
    logic ok_now;
    assign ok_now = mem_cs_q & mem_ok;

    always_comb begin
        // NOTE: every signal gets a default up front so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        tcnt_d      = tcnt_q;
        ok_seen_d   = ok_seen_q;
        hold_d      = hold_q;
        cpu_din_d   = cpu_din_q;
        dtack_d     = dtack_q;
        bus_err_d   = 1'b0;
        mem_cs_d    = mem_cs_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (cen && cpu_as) begin
                    mem_addr_d  = cpu_addr;
                    mem_we_d    = cpu_we;
                    mem_wdata_d = cpu_dout;
                    mem_cs_d    = 1'b1;
                    wcnt_d      = WAIT_C;
                    tcnt_d      = 8'd0;
                    ok_seen_d   = 1'b0;
                    state_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // The backend handshake runs at full clk rate, not on cen.
                if (ok_now) begin
                    ok_seen_d = 1'b1;
                    mem_cs_d  = 1'b0;
                    if (!mem_we_q) hold_d = mem_rdata;
                end
                if (cen) begin
                    if (!cpu_as) begin
                        mem_cs_d = 1'b0;
                        state_d  = ST_IDLE;
                    end else begin
                        wcnt_d = (wcnt_q != 4'd0) ? wcnt_q - 4'd1 : 4'd0;
                        tcnt_d = tcnt_q + 8'd1;
                        if (wcnt_q == 4'd0 && (ok_seen_q || ok_now)) begin
                            dtack_d = 1'b1;
                            if (!mem_we_q) cpu_din_d = ok_now ? mem_rdata : hold_q;
                            state_d = ST_DONE;
                        end else if (tcnt_d == TOUT_C) begin
                            dtack_d   = 1'b1;
                            bus_err_d = 1'b1;
                            mem_cs_d  = 1'b0;
                            if (!mem_we_q) cpu_din_d = 8'hFF;
                            state_d   = ST_DONE;
                        end
                    end
                end
            end
            ST_DONE: begin
                if (cen && !cpu_as) begin
                    dtack_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values computed above.
        if (rst) begin
            state_q     <= ST_IDLE;
            wcnt_q      <= 4'd0;
            tcnt_q      <= 8'd0;
            ok_seen_q   <= 1'b0;
            hold_q      <= 8'd0;
            cpu_din_q   <= 8'd0;
            dtack_q     <= 1'b0;
            bus_err_q   <= 1'b0;
            mem_cs_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 24'd0;
            mem_wdata_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            tcnt_q      <= tcnt_d;
            ok_seen_q   <= ok_seen_d;
            hold_q      <= hold_d;
            cpu_din_q   <= cpu_din_d;
            dtack_q     <= dtack_d;
            bus_err_q   <= bus_err_d;
            mem_cs_q    <= mem_cs_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign cpu_din   = cpu_din_q;
    assign dtack     = dtack_q;
    assign bus_err   = bus_err_q;
    assign mem_cs    = mem_cs_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_jtkcpu_busresp.sv
// Directed bench for jtkcpu_busresp: main instance (WAIT=2, TOUT=255) plus a
// short-timeout instance (WAIT=2, TOUT=8) sharing the same stimulus.
module tb_jtkcpu_busresp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cen = 1'b0;
    logic        cpu_as = 1'b0;
    logic        cpu_we = 1'b0;
    logic [23:0] cpu_addr = '0;
    logic [7:0]  cpu_dout = '0;
    logic [7:0]  mem_rdata = '0;
    logic        mem_ok = 1'b0;

    logic [7:0]  cpu_din,   cpu_din_t;
    logic        dtack,     dtack_t;
    logic        bus_err,   bus_err_t;
    logic        mem_cs,    mem_cs_t;
    logic        mem_we,    mem_we_t;
    logic [23:0] mem_addr,  mem_addr_t;
    logic [7:0]  mem_wdata, mem_wdata_t;

    int n_cmp = 0;
    int n_err = 0;

    jtkcpu_busresp #(.WAIT(2), .TOUT(255)) dut (
        .clk(clk), .rst(rst), .cen(cen), .cpu_as(cpu_as), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_din(cpu_din),
        .dtack(dtack), .bus_err(bus_err), .mem_cs(mem_cs), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ok(mem_ok)
    );

    jtkcpu_busresp #(.WAIT(2), .TOUT(8)) dut_to (
        .clk(clk), .rst(rst), .cen(cen), .cpu_as(cpu_as), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_din(cpu_din_t),
        .dtack(dtack_t), .bus_err(bus_err_t), .mem_cs(mem_cs_t), .mem_we(mem_we_t),
        .mem_addr(mem_addr_t), .mem_wdata(mem_wdata_t), .mem_rdata(mem_rdata),
        .mem_ok(mem_ok)
    );

    always #5 clk = ~clk;

    // cen toggles on negedges, so it is high on every second rising edge.
    initial forever begin
        @(negedge clk);
        cen = ~cen;
    end

    task automatic clk_tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cen_tick();
        @(posedge clk);
        while (!cen) @(posedge clk);
        #1;
    endtask

    task automatic start_access(input logic we, input logic [23:0] addr, input logic [7:0] wd);
        cpu_as = 1'b1; cpu_we = we; cpu_addr = addr; cpu_dout = wd;
        cen_tick();
        n_cmp++; if (mem_cs !== 1'b1) begin n_err++; $display("FAIL accept_cs: got %b want 1", mem_cs); end
        n_cmp++; if (mem_addr !== addr) begin n_err++; $display("FAIL accept_addr: got %h want %h", mem_addr, addr); end
    endtask

    task automatic release_bus();
        cpu_as = 1'b0;
        cen_tick();
        n_cmp++; if (dtack !== 1'b0) begin n_err++; $display("FAIL release_dtack: got %b want 0", dtack); end
    endtask

    // Read with mem_ok on the first clk after mem_cs rises; leaves dtack high.
    task automatic do_read(input logic [23:0] addr, input logic [7:0] data);
        start_access(1'b0, addr, 8'h00);
        mem_ok = 1'b1; mem_rdata = data;
        clk_tick();
        mem_ok = 1'b0; mem_rdata = 8'h00;
        n_cmp++; if (mem_cs !== 1'b0) begin n_err++; $display("FAIL read_cs_drop: got %b want 0", mem_cs); end
        for (int i = 1; i <= 2; i++) begin
            cen_tick();
            n_cmp++; if (dtack !== 1'b0) begin n_err++; $display("FAIL read_early_dtack cen%0d: got %b want 0", i, dtack); end
            n_cmp++; if (mem_cs !== 1'b0) begin n_err++; $display("FAIL read_cs_low cen%0d: got %b want 0", i, mem_cs); end
        end
        cen_tick();
        n_cmp++; if (dtack !== 1'b1) begin n_err++; $display("FAIL read_dtack: got %b want 1", dtack); end
        n_cmp++; if (cpu_din !== data) begin n_err++; $display("FAIL read_data: got %h want %h", cpu_din, data); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) clk_tick();
        n_cmp++; if ({cpu_din, dtack, bus_err, mem_cs, mem_we, mem_addr, mem_wdata} !== 59'd0) begin
            n_err++; $display("FAIL reset_outputs: got din=%h dtack=%b err=%b cs=%b we=%b addr=%h wd=%h want all 0",
                cpu_din, dtack, bus_err, mem_cs, mem_we, mem_addr, mem_wdata);
        end
        rst = 1'b0;
    endtask

    task automatic test_read_instant();
        do_read(24'h001234, 8'h5A);
        release_bus();
    endtask

    task automatic test_write_slow();
        start_access(1'b1, 24'hFF0010, 8'hC3);
        n_cmp++; if (mem_we !== 1'b1) begin n_err++; $display("FAIL write_we: got %b want 1", mem_we); end
        n_cmp++; if (mem_wdata !== 8'hC3) begin n_err++; $display("FAIL write_wdata: got %h want c3", mem_wdata); end
        for (int i = 1; i <= 9; i++) begin
            cen_tick();
            n_cmp++; if (dtack !== 1'b0 || mem_cs !== 1'b1) begin
                n_err++; $display("FAIL write_wait cen%0d: got dtack=%b cs=%b want 0/1", i, dtack, mem_cs);
            end
        end
        clk_tick();
        mem_ok = 1'b1;
        cen_tick();
        mem_ok = 1'b0;
        n_cmp++; if (dtack !== 1'b1) begin n_err++; $display("FAIL write_dtack: got %b want 1", dtack); end
        n_cmp++; if (cpu_din !== 8'h5A) begin n_err++; $display("FAIL write_din_kept: got %h want 5a", cpu_din); end
        clk_tick();
        n_cmp++; if (mem_cs !== 1'b0) begin n_err++; $display("FAIL write_cs_drop: got %b want 0", mem_cs); end
        release_bus();
    endtask

    task automatic test_timeout();
        // No backend answer: error completion on the 8th cen.
        start_access(1'b0, 24'h00ABCD, 8'h00);
        for (int i = 1; i <= 7; i++) begin
            cen_tick();
            n_cmp++; if (dtack_t !== 1'b0 || bus_err_t !== 1'b0) begin
                n_err++; $display("FAIL tout_early cen%0d: got dtack=%b err=%b want 0/0", i, dtack_t, bus_err_t);
            end
        end
        cen_tick();
        n_cmp++; if ({dtack_t, bus_err_t, mem_cs_t, cpu_din_t} !== {1'b1, 1'b1, 1'b0, 8'hFF}) begin
            n_err++; $display("FAIL tout_fire: got dtack=%b err=%b cs=%b din=%h want 1/1/0/ff", dtack_t, bus_err_t, mem_cs_t, cpu_din_t);
        end
        clk_tick();
        n_cmp++; if (bus_err_t !== 1'b0 || dtack_t !== 1'b1) begin
            n_err++; $display("FAIL tout_pulse: got err=%b dtack=%b want 0/1", bus_err_t, dtack_t);
        end
        release_bus();
        // Backend answers on the 8th cen itself: completion wins.
        start_access(1'b0, 24'h00ABCE, 8'h00);
        for (int i = 1; i <= 7; i++) cen_tick();
        clk_tick();
        mem_ok = 1'b1; mem_rdata = 8'h3C;
        cen_tick();
        mem_ok = 1'b0; mem_rdata = 8'h00;
        n_cmp++; if ({dtack_t, bus_err_t, cpu_din_t} !== {1'b1, 1'b0, 8'h3C}) begin
            n_err++; $display("FAIL tout_race: got dtack=%b err=%b din=%h want 1/0/3c", dtack_t, bus_err_t, cpu_din_t);
        end
        clk_tick();
        n_cmp++; if (bus_err_t !== 1'b0) begin n_err++; $display("FAIL tout_race_noerr: got %b want 0", bus_err_t); end
        release_bus();
    endtask

    task automatic test_abort();
        start_access(1'b0, 24'h000100, 8'h00);
        cpu_as = 1'b0;
        cen_tick();
        n_cmp++; if (mem_cs !== 1'b0 || dtack !== 1'b0) begin
            n_err++; $display("FAIL abort: got cs=%b dtack=%b want 0/0", mem_cs, dtack);
        end
        mem_ok = 1'b1; mem_rdata = 8'h77;
        for (int i = 1; i <= 2; i++) begin
            cen_tick();
            n_cmp++; if ({mem_cs, dtack, bus_err, cpu_din} !== {3'b000, 8'h3C}) begin
                n_err++; $display("FAIL abort_late_ok cen%0d: got cs=%b dtack=%b err=%b din=%h want 0/0/0/3c", i, mem_cs, dtack, bus_err, cpu_din);
            end
        end
        mem_ok = 1'b0; mem_rdata = 8'h00;
        do_read(24'h000200, 8'hA5);
        release_bus();
    endtask

    task automatic test_back_to_back();
        do_read(24'h000300, 8'h96);
        for (int i = 1; i <= 5; i++) begin
            cen_tick();
            n_cmp++; if (dtack !== 1'b1 || cpu_din !== 8'h96) begin
                n_err++; $display("FAIL hold_dtack cen%0d: got dtack=%b din=%h want 1/96", i, dtack, cpu_din);
            end
        end
        release_bus();
        start_access(1'b1, 24'h000400, 8'h11);
        n_cmp++; if (mem_we !== 1'b1 || mem_wdata !== 8'h11) begin
            n_err++; $display("FAIL b2b_write: got we=%b wd=%h want 1/11", mem_we, mem_wdata);
        end
        mem_ok = 1'b1;
        clk_tick();
        mem_ok = 1'b0;
        repeat (3) cen_tick();
        n_cmp++; if (dtack !== 1'b1 || cpu_din !== 8'h96) begin
            n_err++; $display("FAIL b2b_done: got dtack=%b din=%h want 1/96", dtack, cpu_din);
        end
        release_bus();
    endtask

    task automatic test_reset_mid_wait();
        start_access(1'b0, 24'h00F00D, 8'h00);
        cen_tick();
        rst = 1'b1; cpu_as = 1'b0;
        clk_tick();
        rst = 1'b0;
        n_cmp++; if ({cpu_din, dtack, bus_err, mem_cs, mem_we, mem_addr, mem_wdata} !== 59'd0) begin
            n_err++; $display("FAIL midreset_outputs: got din=%h dtack=%b err=%b cs=%b we=%b addr=%h wd=%h want all 0",
                cpu_din, dtack, bus_err, mem_cs, mem_we, mem_addr, mem_wdata);
        end
        repeat (2) cen_tick();
        n_cmp++; if (dtack !== 1'b0 || mem_cs !== 1'b0) begin
            n_err++; $display("FAIL midreset_idle: got dtack=%b cs=%b want 0/0", dtack, mem_cs);
        end
        test_read_instant();
    endtask

    initial begin
        test_reset();
        test_read_instant();
        test_write_slow();
        test_timeout();
        test_abort();
        test_back_to_back();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/jtkcpu_busresp.md
# jtkcpu_busresp

Bus responder for the jtkcpu memory bus: the target-side counterpart of the CPU's `addr`/`dout`/`din`/`we`/`dtack` interface. It accepts one CPU access per address-strobe assertion, forwards it to a backend memory port with a `cs`/`ok` handshake, and inserts a programmable minimum number of wait states. It returns read data and `dtack` to the CPU, and signals a bus error when the backend does not answer in time. It sits between the CPU and the system memory arbiter (ROM/RAM/SDRAM).

## Interface
Parameters:
- `WAIT`, 2: minimum wait states, counted in `cen` cycles, before `dtack` may rise (0–15).
- `TOUT`, 255: timeout in `cen` cycles spent in WAIT before a forced error completion (1–255).

Ports:
- `clk` in 1: system clock, the only clock.
- `rst` in 1: synchronous, active-high reset.
- `cen` in 1: CPU clock enable; all state transitions are qualified by it, except backend capture.
- `cpu_as` in 1: CPU address strobe; a high level requests an access.
- `cpu_we` in 1: 1 = write, 0 = read.
- `cpu_addr` in 24: CPU address.
- `cpu_dout` in 8: CPU write data.
- `cpu_din` out 8: read data returned to the CPU.
- `dtack` out 1: data acknowledge to the CPU.
- `bus_err` out 1: one-`clk` pulse on timeout.
- `mem_cs` out 1: backend request.
- `mem_we` out 1: backend write enable.
- `mem_addr` out 24: latched address.
- `mem_wdata` out 8: latched write data.
- `mem_rdata` in 8: backend read data, valid while `mem_ok`.
- `mem_ok` in 1: backend acknowledge; may arrive on any `clk`.

## Operation
- States: IDLE, WAIT, DONE. Reset forces IDLE. On reset, all outputs are 0, including `cpu_din`=0x00, and the internal wait count, timeout count and `ok_seen` are cleared.
- IDLE → WAIT on a `cen` edge with `cpu_as`=1:
  - latch `cpu_addr`→`mem_addr`, `cpu_we`→`mem_we`, `cpu_dout`→`mem_wdata`;
  - set `mem_cs`=1, wait count=`WAIT`, timeout count=0, `ok_seen`=0.
- In WAIT, on every `clk` with `mem_cs`=1 and `mem_ok`=1:
  - set `ok_seen`=1;
  - for reads, capture `mem_rdata` into a holding register;
  - `mem_cs` drops on the following `clk`.
- In WAIT, on each `cen`:
  - The wait count decrements, saturating at 0, and the timeout count increments.
  - Completion when wait count is 0 and (`ok_seen` or `mem_ok`): `dtack`=1; reads load `cpu_din` from the holding register, or directly from `mem_rdata` if `mem_ok` is concurrent; writes leave `cpu_din` unchanged. Go to DONE.
  - Otherwise, when the timeout count reaches `TOUT`: `dtack`=1, `cpu_din`=0xFF for reads, `bus_err` pulses for one `clk`, `mem_cs`=0. Go to DONE.
  - If completion and timeout fall on the same `cen`, completion wins and `bus_err` does not pulse.
  - Abort: `cpu_as`=0 seen on a `cen` in WAIT gives `mem_cs`=0, no `dtack`, and a return to IDLE. A `mem_ok` arriving afterwards is ignored. Abort has priority over both completion and timeout.
- DONE: `dtack` stays 1 until a `cen` with `cpu_as`=0. Then `dtack`=0 and the block returns to IDLE. A new access can be accepted no earlier than the next `cen`, so at least one idle `cen` separates back-to-back accesses.
- `cpu_din`, `mem_addr`, `mem_we` and `mem_wdata` hold their values between accesses.

## Timing
- Acceptance on `cen` edge N.
- Minimum latency: `dtack` rises at `cen` edge N+`WAIT`+1 when `mem_ok` has already been seen. With `WAIT`=0 that is the very next `cen`.
- A late `mem_ok` at `clk` edge t: `dtack` rises on the first `cen` edge at or after t on which the wait count is 0.
- `mem_cs` is high from the `clk` after N until the `clk` after `mem_ok`, or until abort or timeout.
- `bus_err` and the rise of `dtack` on timeout occur on the same `clk` edge, the `TOUT`-th `cen` after N.
- `cpu_din` is valid on the same edge `dtack` rises and remains stable while `dtack`=1.
- Reset mid-access: outputs are 0 on the next `clk` edge, with no `bus_err`.

## Test plan
- **Read, instant backend:** `WAIT`=2, `cen` every 2nd `clk`, read 0x001234, `mem_ok` with 0x5A on the first `clk` after `mem_cs` rises → `dtack` at 3rd `cen` after acceptance; `cpu_din`=0x5A; `mem_cs` low for one `clk` after `mem_ok`.
- **Write, slow backend:** write 0xC3 to 0xFF0010, `mem_ok` 10 `cen` later → `mem_we`=1, `mem_wdata`=0xC3, `mem_addr`=0xFF0010; `dtack` on the `cen` of `mem_ok`; `cpu_din` unchanged.
- **Timeout:** `TOUT`=8, read with no `mem_ok` → at the 8th `cen`, `dtack`=1, `cpu_din`=0xFF, a single-`clk` `bus_err`; `mem_ok` at the same `cen` instead → normal completion with no `bus_err`.
- **Abort:** drop `cpu_as` at the 1st `cen` of WAIT → `mem_cs`=0, `dtack` never rises; a later `mem_ok` causes no state change; the next access completes normally.
- **Handshake release:** hold `cpu_as` high for 5 `cen` after `dtack` → `dtack` stays 1; it falls on the `cen` where `cpu_as`=0; a back-to-back access is accepted on the following `cen`.
- **Reset mid-WAIT:** assert `rst` for one `clk` during WAIT → all outputs 0, state IDLE; the subsequent access matches the first scenario.
